regfile_mp: RTL and testbench

REGFILE_MP -- requirements
Module: regfile_mp

---
 rtl/regfile_mp.sv | 132 +++++++++++++
 tb/tb_regfile_mp.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/regfile_mp.sv
// Multi-ported register file with a pending-write scoreboard.
// After reset a CLEAR sequence zeroes one register per cycle, and the
// file then runs. Reads are combinational and forward same-cycle writes.
// Register 0 is hard-wired to zero and is never marked busy.
module regfile_mp #(
   parameter int XLEN = 32,
   parameter int NREG = 32,
   parameter int NRD  = 2,
   parameter int NWR  = 2,
   localparam int AW  = $clog2(NREG)
) (
   input  logic                      clk,
   input  logic                      rst,
   output logic                      ready_o,
   input  logic [NRD-1:0][AW-1:0]    rd_addr_i,
   output logic [NRD-1:0][XLEN-1:0]  rd_data_o,
   output logic [NRD-1:0]            rd_busy_o,
   input  logic [NWR-1:0]            wr_en_i,
   input  logic [NWR-1:0][AW-1:0]    wr_addr_i,
   input  logic [NWR-1:0][XLEN-1:0]  wr_data_i,
   input  logic                      alloc_en_i,
   input  logic [AW-1:0]             alloc_addr_i,
   input  logic                      flush_i
);

   typedef enum logic {CLEAR, RUN} state_e;

   state_e              state_q, state_d;
   logic [AW-1:0]       idx_q, idx_d;
   logic [XLEN-1:0]     regs_q [NREG];
   logic [XLEN-1:0]     regs_d [NREG];
   logic [NREG-1:0]     busy_q, busy_d;
   logic [NRD-1:0]              fwd_hit;
   logic [NRD-1:0][XLEN-1:0]    fwd_data;

   assign ready_o = (state_q == RUN);

   // Control state, clear index and scoreboard; synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q <= CLEAR;
         idx_q   <= '0;
         busy_q  <= '0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         busy_q  <= busy_d;
      end
   end

   // Register storage; contents are not reset, the CLEAR sequence zeroes them.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int unsigned i = 0; i < NREG; i++) begin
            regs_q[i] <= regs_d[i];
         end
      end
   end

   // Next state: walk the clear index once through every register, then run.
   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      if (state_q == CLEAR) begin
         idx_d = idx_q + 1'b1;
         if (idx_q == AW'(NREG - 1)) begin
            state_d = RUN;
         end
      end
   end

   // Next register contents: clear one entry, or apply writes in port order
   // so the highest-numbered port wins an address collision.
   always_comb begin
      for (int unsigned i = 0; i < NREG; i++) begin
         regs_d[i] = regs_q[i];
      end
      if (state_q == CLEAR) begin
         regs_d[idx_q] = '0;
      end else begin
         for (int unsigned p = 0; p < NWR; p++) begin
            if (wr_en_i[p] && (wr_addr_i[p] != '0)) begin
               regs_d[wr_addr_i[p]] = wr_data_i[p];
            end
         end
      end
      regs_d[0] = '0;
   end

   // Next scoreboard: writes clear, alloc sets afterwards so it wins, flush
   // overrides everything.
   always_comb begin
      busy_d = busy_q;
      if (state_q == CLEAR) begin
         busy_d = '0;
      end else begin
         for (int unsigned p = 0; p < NWR; p++) begin
            if (wr_en_i[p] && (wr_addr_i[p] != '0)) begin
               busy_d[wr_addr_i[p]] = 1'b0;
            end
         end
         if (alloc_en_i && (alloc_addr_i != '0)) begin
            busy_d[alloc_addr_i] = 1'b1;
         end
         if (flush_i) begin
            busy_d = '0;
         end
      end
      busy_d[0] = 1'b0;
   end

   // Read ports: zero register, write forwarding, stored value; quiet in CLEAR.
   always_comb begin
      fwd_hit   = '0;
      fwd_data  = '0;
      rd_data_o = '0;
      rd_busy_o = '0;
      for (int unsigned r = 0; r < NRD; r++) begin
         for (int unsigned p = 0; p < NWR; p++) begin
            if (wr_en_i[p] && (wr_addr_i[p] == rd_addr_i[r])) begin
               fwd_hit[r]  = 1'b1;
               fwd_data[r] = wr_data_i[p];
            end
         end
         if ((state_q == RUN) && (rd_addr_i[r] != '0)) begin
            rd_data_o[r] = fwd_hit[r] ? fwd_data[r] : regs_q[rd_addr_i[r]];
            rd_busy_o[r] = busy_q[rd_addr_i[r]] && !fwd_hit[r];
         end
      end
   end

endmodule

// File: tb/tb_regfile_mp.sv
// Directed bench for regfile_mp with a behavioural reference model that is
// compared against every output on every falling clock edge.
module tb_regfile_mp;

   localparam int XLEN = 32;
   localparam int NREG = 32;
   localparam int NRD  = 2;
   localparam int NWR  = 2;
   localparam int AW   = 5;

   logic                     clk = 1'b0;
   logic                     rst;
   logic                     ready;
   logic [NRD-1:0][AW-1:0]   rd_addr;
   logic [NRD-1:0][XLEN-1:0] rd_data;
   logic [NRD-1:0]           rd_busy;
   logic [NWR-1:0]           wr_en;
   logic [NWR-1:0][AW-1:0]   wr_addr;
   logic [NWR-1:0][XLEN-1:0] wr_data;
   logic                     alloc_en;
   logic [AW-1:0]            alloc_addr;
   logic                     flush;

   int n_cmp = 0;
   int n_bad = 0;

   regfile_mp #(.XLEN(XLEN), .NREG(NREG), .NRD(NRD), .NWR(NWR)) dut (
      .clk          (clk),
      .rst          (rst),
      .ready_o      (ready),
      .rd_addr_i    (rd_addr),
      .rd_data_o    (rd_data),
      .rd_busy_o    (rd_busy),
      .wr_en_i      (wr_en),
      .wr_addr_i    (wr_addr),
      .wr_data_i    (wr_data),
      .alloc_en_i   (alloc_en),
      .alloc_addr_i (alloc_addr),
      .flush_i      (flush)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: a plain array, a busy vector and a count of clear cycles.
   logic [31:0] m_reg [NREG];
   logic [31:0] m_busy;
   bit          m_ready = 1'b0;
   int          m_cnt = 0;
   bit          started = 1'b0;

   always @(posedge clk) begin
      started = 1'b1;
      if (!rst) begin
         m_ready = 1'b0;
         m_cnt   = 0;
         m_busy  = '0;
         for (int i = 0; i < NREG; i++) m_reg[i] = '0;
      end else if (!m_ready) begin
         m_cnt++;
         if (m_cnt == NREG) m_ready = 1'b1;
      end else begin
         for (int p = 0; p < NWR; p++) begin
            if (wr_en[p] && wr_addr[p] != 0) begin
               m_reg[wr_addr[p]]  = wr_data[p];
               m_busy[wr_addr[p]] = 1'b0;
            end
         end
         if (alloc_en && alloc_addr != 0) m_busy[alloc_addr] = 1'b1;
         if (flush) m_busy = '0;
      end
   end

   function automatic logic [31:0] exp_data(input logic [AW-1:0] a);
      logic [31:0] v;
      if (!m_ready || a == 0) return '0;
      v = m_reg[a];
      for (int p = 0; p < NWR; p++) if (wr_en[p] && wr_addr[p] == a) v = wr_data[p];
      return v;
   endfunction

   function automatic logic exp_busy(input logic [AW-1:0] a);
      if (!m_ready || a == 0) return 1'b0;
      for (int p = 0; p < NWR; p++) if (wr_en[p] && wr_addr[p] == a) return 1'b0;
      return m_busy[a];
   endfunction

   always @(negedge clk) begin
      if (started) begin
         chk("model_ready", {31'b0, ready}, {31'b0, m_ready});
         for (int r = 0; r < NRD; r++) begin
            chk($sformatf("model_rd_data[%0d]", r), rd_data[r], exp_data(rd_addr[r]));
            chk($sformatf("model_rd_busy[%0d]", r), {31'b0, rd_busy[r]},
                {31'b0, exp_busy(rd_addr[r])});
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic idle();
      wr_en    = '0;
      alloc_en = 1'b0;
      flush    = 1'b0;
   endtask

   // Checks ready is low for exactly 32 cycles after release, high on the 33rd.
   task automatic ready_window(input string tag);
      for (int c = 1; c <= 33; c++) begin
         #1 chk($sformatf("%s_ready_c%0d", tag, c), {31'b0, ready}, (c == 33) ? 32'd1 : 32'd0);
         tick();
      end
   endtask

   initial begin
      rst = 1'b0;
      rd_addr = '0; wr_addr = '0; wr_data = '0; alloc_addr = '0;
      idle();
      tick();
      tick();
      rst = 1'b1;
      rd_addr[0] = 5'd5;
      rd_addr[1] = 5'd31;
      ready_window("rst");

      for (int a = 1; a < NREG; a++) begin
         rd_addr[0] = 5'(a);
         rd_addr[1] = 5'(NREG - a);
         #1 chk("zero_scan", rd_data[0], 32'h0);
         tick();
      end

      // write with same-cycle bypass
      wr_en = 2'b01; wr_addr[0] = 5'd5; wr_data[0] = 32'hDEADBEEF; rd_addr[0] = 5'd5;
      #1 chk("bypass", rd_data[0], 32'hDEADBEEF);
      tick(); idle();
      #1 chk("wr_persist", rd_data[0], 32'hDEADBEEF);

      // collision, port 1 wins
      wr_en = 2'b11; wr_addr[0] = 5'd7; wr_addr[1] = 5'd7;
      wr_data[0] = 32'h11111111; wr_data[1] = 32'h22222222; rd_addr[1] = 5'd7;
      #1 chk("collide_bypass", rd_data[1], 32'h22222222);
      tick(); idle();
      #1 chk("collide_store", rd_data[1], 32'h22222222);

      // register 0
      wr_en = 2'b01; wr_addr[0] = 5'd0; wr_data[0] = 32'hFFFFFFFF;
      alloc_en = 1'b1; alloc_addr = 5'd0; rd_addr[0] = 5'd0;
      #1 chk("x0_data_bypass", rd_data[0], 32'h0);
      chk("x0_busy_bypass", {31'b0, rd_busy[0]}, 32'h0);
      tick(); idle();
      #1 chk("x0_data", rd_data[0], 32'h0);
      chk("x0_busy", {31'b0, rd_busy[0]}, 32'h0);

      // scoreboard
      rd_addr[0] = 5'd9; alloc_en = 1'b1; alloc_addr = 5'd9;
      #1 chk("sb_pre", {31'b0, rd_busy[0]}, 32'h0);
      tick(); idle();
      #1 chk("sb_alloc", {31'b0, rd_busy[0]}, 32'h1);
      alloc_en = 1'b1; alloc_addr = 5'd9;
      wr_en = 2'b10; wr_addr[1] = 5'd9; wr_data[1] = 32'h99999999;
      #1 chk("sb_alloc_wr_now", {31'b0, rd_busy[0]}, 32'h0);
      tick(); idle();
      #1 chk("sb_alloc_wins", {31'b0, rd_busy[0]}, 32'h1);
      chk("sb_data9", rd_data[0], 32'h99999999);
      wr_en = 2'b01; wr_addr[0] = 5'd9; wr_data[0] = 32'h12345678;
      #1 chk("sb_wr_now", {31'b0, rd_busy[0]}, 32'h0);
      tick(); idle();
      #1 chk("sb_wr_clear", {31'b0, rd_busy[0]}, 32'h0);
      chk("sb_wr_data", rd_data[0], 32'h12345678);

      // flush overrides alloc and clears others; write still lands
      alloc_en = 1'b1; alloc_addr = 5'd9;
      tick(); idle();
      #1 chk("fl_pre9", {31'b0, rd_busy[0]}, 32'h1);
      alloc_en = 1'b1; alloc_addr = 5'd3; flush = 1'b1; rd_addr[1] = 5'd3;
      wr_en = 2'b01; wr_addr[0] = 5'd4; wr_data[0] = 32'h44444444;
      tick(); idle();
      #1 chk("fl_busy3", {31'b0, rd_busy[1]}, 32'h0);
      chk("fl_busy9", {31'b0, rd_busy[0]}, 32'h0);
      rd_addr[1] = 5'd4;
      #1 chk("fl_wr4", rd_data[1], 32'h44444444);

      // reset in the middle of the clear sequence
      rd_addr[0] = 5'd5; rd_addr[1] = 5'd10;
      alloc_en = 1'b1; alloc_addr = 5'd10;
      tick(); idle();
      #1 chk("mid_pre5", rd_data[0], 32'hDEADBEEF);
      chk("mid_pre_busy10", {31'b0, rd_busy[1]}, 32'h1);
      rst = 1'b0;
      tick();
      rst = 1'b1;
      repeat (12) tick();
      #1 chk("mid_idx12_ready", {31'b0, ready}, 32'h0);
      rst = 1'b0;
      tick();
      rst = 1'b1;
      ready_window("mid");
      #1 chk("mid_reg5", rd_data[0], 32'h0);
      chk("mid_busy10", {31'b0, rd_busy[1]}, 32'h0);
      tick();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
